// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the EX/MEM stage control groups.
package hazard_pkg;

    // Sequencing state of the hazard controller
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    // Architectural zero register; never a real load destination
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit positions of the M control group carried by ID_EX and EX_MEM
    localparam int unsigned M_W             = 3;
    localparam int unsigned M_MEM_WRITE_BIT = 0;
    localparam int unsigned M_MEM_READ_BIT  = 1;
    localparam int unsigned M_BRANCH_BIT    = 2;

    // Load in ID_EX writes a register the instruction in IF_ID reads
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, holding at the all-ones value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline:
// load-use stalls, MEM-stage branch flushes, data-memory wait/timeout.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_write,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             pc_src,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = 16;

    hz_state_t         r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err_timeout;

    logic w_mem_wait;
    logic w_taken;
    logic w_load_use;
    logic w_active;
    logic w_wait_limit;
    logic w_stall_inc;
    logic w_flush_inc;

    // Hazard decode and counter increment qualifiers
    always_comb begin
        w_mem_wait   = mem_access & ~dmem_ready;
        w_taken      = mem_branch & mem_zero;
        w_load_use   = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
        w_active     = ~rst & (r_state != TIMEOUT);
        w_wait_limit = (({1'b0, r_wait_cnt} + 17'd1) >= 17'(WAIT_MAX));
        w_stall_inc  = w_active & (w_mem_wait | (~w_taken & w_load_use));
        w_flush_inc  = w_active & ~w_mem_wait & w_taken;
    end

    // Per-cycle pipeline controls by priority: reset, timeout, wait, branch, load-use
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        pipe_write    = 1'b1;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        pc_src        = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_write    = 1'b0;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
        end else if ((r_state == TIMEOUT) || w_mem_wait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_write    = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (w_taken) begin
            pc_src        = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
        end else if (w_load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    // Sequencing state, consecutive-wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                RUN, MEM_WAIT: begin
                    if (w_mem_wait) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (w_wait_limit) begin
                            r_state       <= TIMEOUT;
                            r_err_timeout <= 1'b1;
                        end else begin
                            r_state <= MEM_WAIT;
                        end
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end
                end
                TIMEOUT: begin
                    r_state       <= TIMEOUT;
                    r_err_timeout <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign err_timeout = r_err_timeout;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test of pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // Control vector order: pc_write, if_id_write, pipe_write, id_ex_bubble,
    // mem_wb_bubble, pc_src, flush_if_id, flush_id_ex, flush_ex_mem
    localparam logic [8:0] C_NORMAL = 9'b111_000_000;
    localparam logic [8:0] C_LU     = 9'b001_100_000;
    localparam logic [8:0] C_FREEZE = 9'b000_010_000;
    localparam logic [8:0] C_BRANCH = 9'b111_001_111;
    localparam logic [8:0] C_RST    = 9'b000_110_111;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_access, dmem_ready;
    logic             pc_write, if_id_write, pipe_write, id_ex_bubble, mem_wb_bubble;
    logic             pc_src, flush_if_id, flush_id_ex, flush_ex_mem, err_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       ctl;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .mem_branch    (mem_branch),
        .mem_zero      (mem_zero),
        .mem_access    (mem_access),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .pipe_write    (pipe_write),
        .id_ex_bubble  (id_ex_bubble),
        .mem_wb_bubble (mem_wb_bubble),
        .pc_src        (pc_src),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .err_timeout   (err_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, pipe_write, id_ex_bubble, mem_wb_bubble,
                  pc_src, flush_if_id, flush_id_ex, flush_ex_mem};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        mem_branch = 1'b0; mem_zero = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic counters(input string tag, input int s, input int f, input logic e);
        chk({tag, ".stall"}, 32'(stall_cnt), 32'(s));
        chk({tag, ".flush"}, 32'(flush_cnt), 32'(f));
        chk({tag, ".err"},   32'(err_timeout), 32'(e));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        #1 chk("reset_ctl", 32'(ctl), 32'(C_RST));
        counters("reset", 0, 0, 1'b0);

        rst = 1'b0;
        #1 chk("normal", 32'(ctl), 32'(C_NORMAL));

        // Load-use through rs
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("lu_rs", 32'(ctl), 32'(C_LU));
        tick();
        counters("lu_rs", 1, 0, 1'b0);
        ex_mem_read = 1'b0;
        #1 chk("lu_after", 32'(ctl), 32'(C_NORMAL));
        tick();

        // Load-use through rt
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1 chk("lu_rt", 32'(ctl), 32'(C_LU));
        tick();
        counters("lu_rt", 2, 0, 1'b0);

        // No stall on $0 or an unused rt
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("no_lu_r0", 32'(ctl), 32'(C_NORMAL));
        tick();
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
        #1 chk("no_lu_rt_unused", 32'(ctl), 32'(C_NORMAL));
        tick();
        counters("no_lu", 2, 0, 1'b0);

        // Taken and not-taken branch
        idle();
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1 chk("br_taken", 32'(ctl), 32'(C_BRANCH));
        tick();
        counters("br_taken", 2, 1, 1'b0);
        mem_zero = 1'b0;
        #1 chk("br_not_taken", 32'(ctl), 32'(C_NORMAL));
        tick();
        counters("br_not_taken", 2, 1, 1'b0);

        // Branch coincident with load-use: flush only
        mem_zero = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("br_vs_lu", 32'(ctl), 32'(C_BRANCH));
        tick();
        counters("br_vs_lu", 2, 2, 1'b0);

        // Three-cycle memory wait, then ready
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mwait_frz", 32'(ctl), 32'(C_FREEZE));
            tick();
        end
        counters("mwait", 5, 2, 1'b0);
        dmem_ready = 1'b1;
        #1 chk("mwait_ready", 32'(ctl), 32'(C_NORMAL));
        tick();
        counters("mwait_ready", 5, 2, 1'b0);
        #1 chk("mem_first_ready", 32'(ctl), 32'(C_NORMAL));
        tick();
        counters("mem_first_ready", 5, 2, 1'b0);

        // Branch held during a wait is taken on the ready cycle
        mem_branch = 1'b1; mem_zero = 1'b1; dmem_ready = 1'b0;
        #1 chk("br_in_wait", 32'(ctl), 32'(C_FREEZE));
        tick();
        dmem_ready = 1'b1;
        #1 chk("br_on_ready", 32'(ctl), 32'(C_BRANCH));
        tick();
        counters("br_on_ready", 6, 3, 1'b0);

        // Timeout after four not-ready cycles, then frozen until reset
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_pre_err", 32'(err_timeout), 32'(0));
            tick();
        end
        counters("timeout", 10, 3, 1'b1);
        dmem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("to_frozen", 32'(ctl), 32'(C_FREEZE));
            tick();
        end
        counters("to_hold", 10, 3, 1'b1);

        // Reset recovers
        idle();
        rst = 1'b1;
        #1 chk("to_rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        counters("recover", 0, 0, 1'b0);
        rst = 1'b0;
        #1 chk("recover_ctl", 32'(ctl), 32'(C_NORMAL));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline (fetch, decode, execute, memory, write-back). It generates the per-cycle write-enable, bubble and flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves three hazard types: load-use data hazards, taken branches resolved in the memory stage, and multi-cycle data-memory accesses. It also keeps saturating stall and flush statistics and detects a data-memory timeout.

## Interface
- WAIT_MAX, 16: maximum consecutive MEM_WAIT cycles before timeout; legal range 1..65535.
- CNT_W, 16: width of the statistics counters.
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- id_rs  input  5  rs field of the instruction in IF_ID.
- id_rt  input  5  rt field of the instruction in IF_ID.
- id_uses_rt  input  1  decoded instruction reads rt as a source.
- ex_mem_read  input  1  MemRead bit of the M group in ID_EX.
- ex_rt  input  5  rt (load destination) held in ID_EX.
- mem_branch  input  1  Branch bit of the M group in EX_MEM.
- mem_zero  input  1  zero flag held in EX_MEM.
- mem_access  input  1  MemRead or MemWrite active in EX_MEM.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register load enable.
- if_id_write  output  1  IF_ID load enable.
- pipe_write  output  1  load enable for ID_EX, EX_MEM and MEM_WB.
- id_ex_bubble  output  1  load zeros into the WB/M/EX control groups of ID_EX.
- mem_wb_bubble  output  1  load zero WB controls into MEM_WB.
- pc_src  output  1  select the branch target for the next PC.
- flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  clear the stage's control bits on the next edge.
- err_timeout  output  1  sticky data-memory timeout flag.
- stall_cnt  output  CNT_W  cycles spent stalled (load-use or memory wait), saturating.
- flush_cnt  output  CNT_W  taken branches, saturating.

## Operation
- States: RUN, MEM_WAIT, TIMEOUT.
- Control outputs are combinational from the current state and inputs. State, wait counter, statistics and err_timeout are registered.
- Priority within a cycle, highest first: rst, TIMEOUT, memory wait, taken branch, load-use, normal.
- **Memory wait** (mem_access=1, dmem_ready=0):
  - Outputs: pc_write=0, if_id_write=0, pipe_write=0, mem_wb_bubble=1.
  - The state moves to or stays in MEM_WAIT, and wait_cnt increments.
  - When dmem_ready=1, the state returns to RUN, wait_cnt clears, and that cycle is a normal advance.
  - When wait_cnt reaches WAIT_MAX with ready still 0, the state moves to TIMEOUT.
- **Taken branch** (mem_branch=1 and mem_zero=1, no memory wait):
  - Outputs: pc_src=1, flush_if_id=1, flush_id_ex=1, flush_ex_mem=1; all write enables are 1.
  - flush_cnt increments.
  - Load-use detection is suppressed in this cycle.
- **Load-use**:
  - Detected when ex_mem_read=1, ex_rt≠0, and either ex_rt=id_rs or (id_uses_rt=1 and ex_rt=id_rt).
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_write=1.
  - Exactly one bubble is inserted, because the load leaves ID_EX on the next edge.
- **Normal**: all write enables are 1; all flush, bubble and pc_src outputs are 0.
- **TIMEOUT**:
  - err_timeout=1; the pipeline stays frozen (same outputs as memory wait).
  - This state is left only through rst.
- **stall_cnt** increments on every load-use cycle and every cycle frozen by memory wait (MEM_WAIT or the entry cycle). It does not increment in TIMEOUT. Both counters stop at 2^CNT_W−1.
- **Simultaneous branch and memory access**: not architecturally possible. If it occurs, the memory wait wins, and the branch is taken on the ready cycle because the inputs are held by the freeze.

## Timing
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, err_timeout=0.
- While rst=1 (sync, so effective from the edge on which it is sampled):
  - pc_write=0, if_id_write=0, pipe_write=0.
  - All three flushes=1, both bubbles=1.
  - pc_src=0.
- Zero-cycle latency from inputs to control outputs. Registered outputs (counters, err_timeout) update on the same edge that applies the stall or flush.
- A memory access that is ready in its first MEM cycle costs zero stall cycles. An access ready after N waiting cycles costs N stall cycles.
- Timeout is declared on the edge after WAIT_MAX consecutive not-ready cycles.
- rst asserted during MEM_WAIT or TIMEOUT returns to RUN on that edge with counters cleared.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, TIMEOUT);
  - REG_ZERO = 5'd0;
  - the M-group bit positions (MemRead, MemWrite, Branch), shared with the execute and memory stages.
- One sub-module: sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated for stall_cnt and flush_cnt.

## Test plan
- **Load-use via rs**: lw to $5 in ID_EX (ex_mem_read=1, ex_rt=5); id_rs=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1; next cycle normal.
- **No stall on $0 or an unused rt**: ex_rt=0 with id_rs=0 -> no stall. ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
- **Taken branch**: mem_branch=1, mem_zero=1 -> pc_src=1 and all three flushes=1 for one cycle; flush_cnt=1. With mem_zero=0 -> no flush.
- **Branch vs load-use**: taken branch coincident with a load-use match -> branch flush only, id_ex_bubble=0, stall_cnt unchanged.
- **Memory wait**: mem_access=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles (pipe_write=0, mem_wb_bubble=1), then advance; stall_cnt=3.
- **Timeout and recovery**: WAIT_MAX=4 with dmem_ready held low -> err_timeout=1 after 4 cycles and stays frozen; rst pulse -> RUN, err_timeout=0, counters=0.
